// File: rtl/rv_pipe_pkg.sv
// Shared types and helpers for the in-order core pipeline hazard controller.
// Tracker entries carry register fields at a fixed maximum width, so any REG_AW up to RF_AW_MAX fits.
package rv_pipe_pkg;

  localparam int RF_AW_MAX = 8;
  localparam int FWD_NONE  = 0;

  typedef struct packed {
    logic                 valid;
    logic [RF_AW_MAX-1:0] rd;
    logic                 regwrite;
    logic                 is_load;
    logic [RF_AW_MAX-1:0] rs1;
    logic [RF_AW_MAX-1:0] rs2;
    logic                 use1;
    logic                 use2;
  } hz_entry_t;

  // Listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_FETCH_WAIT,
    ACT_RUN
  } hz_action_t;

  function automatic int clog2(input int n);
    int bits;
    int v;
    bits = 0;
    v    = n - 1;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/rv_hazard_tracker.sv
// Shift register mirroring the instructions held in EX..WB.
// Entry 0 is EX; a hold freezes every entry and a bubble inserts an invalid entry at EX.
module rv_hazard_tracker
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   bubble,
  input  hz_entry_t              id_entry,
  output hz_entry_t [DEPTH-1:0]  entries
);

  always_ff @(posedge clk) begin
    // NOTE: whole entries are cleared on reset, not just valid, so stale register fields never linger.
    if (reset) begin
      entries <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments make every stage shift from its pre-edge neighbour.
      entries[0] <= bubble ? '0 : id_entry;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/rv_pipe_hazard_ctrl.sv
// Central pipeline controller: forwarding selects, load-use stalls, branch flushes and memory freezes,
// all derived from a registered copy of the instructions in flight between EX and WB.
module rv_pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      ex_br_taken,
  input  logic                      imem_busy,
  input  logic                      dmem_busy,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      ifid_bubble,
  output logic                      idex_en,
  output logic                      idex_bubble,
  output logic                      back_en,
  output logic                      pc_redirect,
  output logic [clog2(DEPTH)-1:0]   fwd_a,
  output logic [clog2(DEPTH)-1:0]   fwd_b,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int FWD_W = clog2(DEPTH);

  hz_entry_t [DEPTH-1:0]  tracked;
  hz_entry_t              id_entry;
  hz_entry_t              head;
  hz_action_t             action;
  logic [RF_AW_MAX-1:0]   id_rs1_x;
  logic [RF_AW_MAX-1:0]   id_rs2_x;
  logic                   load_use;
  logic [FWD_W-1:0]       fwd_a_raw;
  logic [FWD_W-1:0]       fwd_b_raw;
  logic                   unused_tracked;

  // The regfile is write-first, so only real register writes to a nonzero rd are hazards.
  function automatic logic produces(input hz_entry_t e, input logic [RF_AW_MAX-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

  assign id_rs1_x = RF_AW_MAX'(id_rs1);
  assign id_rs2_x = RF_AW_MAX'(id_rs2);

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.rd       = RF_AW_MAX'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.is_load  = id_is_load;
    id_entry.rs1      = id_rs1_x;
    id_entry.rs2      = id_rs2_x;
    id_entry.use1     = id_use_rs1;
    id_entry.use2     = id_use_rs2;
  end

  rv_hazard_tracker #(
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .hold     (action == ACT_FREEZE),
    .bubble   (idex_bubble),
    .id_entry (id_entry),
    .entries  (tracked)
  );

  assign head           = tracked[0];
  assign unused_tracked = ^tracked;

  // A load in entry j reaches entry j+1 when the ID instruction enters EX; stall until that is forwardable.
  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((j + 1 < LOAD_READY) && tracked[j].is_load) begin
        if ((id_use_rs1 && produces(tracked[j], id_rs1_x)) ||
            (id_use_rs2 && produces(tracked[j], id_rs2_x))) begin
          load_use = 1'b1;
        end
      end
    end
    load_use = load_use && id_valid;
  end

  // Walk from the oldest entry to the newest so the youngest producer wins.
  always_comb begin
    fwd_a_raw = FWD_W'(FWD_NONE);
    fwd_b_raw = FWD_W'(FWD_NONE);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (!(tracked[k].is_load && (k < LOAD_READY))) begin
        if (head.valid && head.use1 && produces(tracked[k], head.rs1)) begin
          fwd_a_raw = FWD_W'(k);
        end
        if (head.valid && head.use2 && produces(tracked[k], head.rs2)) begin
          fwd_b_raw = FWD_W'(k);
        end
      end
    end
  end

  // A taken branch squashes the ID instruction, so its load-use hazard is moot.
  always_comb begin
    if (reset) begin
      action = ACT_RESET;
    end else if (dmem_busy) begin
      action = ACT_FREEZE;
    end else if (ex_br_taken) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_STALL;
    end else if (imem_busy) begin
      action = ACT_FETCH_WAIT;
    end else begin
      action = ACT_RUN;
    end
  end

  always_comb begin
    // NOTE: every output is defaulted before the case, so no path can infer a latch.
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_bubble = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    back_en     = 1'b1;
    pc_redirect = 1'b0;
    unique case (action)
      ACT_RESET: begin
        pc_en       = 1'b0;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
      end
      ACT_FREEZE: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        back_en = 1'b0;
      end
      ACT_FLUSH: begin
        pc_redirect = 1'b1;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
      end
      ACT_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      ACT_FETCH_WAIT: begin
        pc_en       = 1'b0;
        ifid_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fwd_a = (action == ACT_RESET) ? FWD_W'(FWD_NONE) : fwd_a_raw;
  assign fwd_b = (action == ACT_RESET) ? FWD_W'(FWD_NONE) : fwd_b_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (((action == ACT_STALL) || (action == ACT_FREEZE)) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((action == ACT_FLUSH) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_pipe_hazard_ctrl.sv
// Directed bench for rv_pipe_hazard_ctrl: a DEPTH=3/LOAD_READY=2 instance and a DEPTH=4/LOAD_READY=3
// instance share one stimulus stream; each scenario checks only the instance it targets.
module tb_rv_pipe_hazard_ctrl;

  localparam logic [6:0] C_RESET = 7'b0111110;
  localparam logic [6:0] C_RUN   = 7'b1101010;
  localparam logic [6:0] C_STALL = 7'b0001110;
  localparam logic [6:0] C_FLUSH = 7'b1111111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_IWAIT = 7'b0111010;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic       ex_br_taken, imem_busy, dmem_busy;

  logic        pc_en, ifid_en, ifid_bubble, idex_en, idex_bubble, back_en, pc_redirect;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, ifid_bubble4, idex_en4, idex_bubble4, back_en4, pc_redirect4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [31:0] stall_cnt4, flush_cnt4;

  logic [6:0] ctrl, ctrl4;
  assign ctrl  = {pc_en, ifid_en, ifid_bubble, idex_en, idex_bubble, back_en, pc_redirect};
  assign ctrl4 = {pc_en4, ifid_en4, ifid_bubble4, idex_en4, idex_bubble4, back_en4, pc_redirect4};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_bubble(ifid_bubble), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .back_en(back_en), .pc_redirect(pc_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  rv_pipe_hazard_ctrl #(.DEPTH(4), .LOAD_READY(3)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_bubble(ifid_bubble4), .idex_en(idex_en4),
    .idex_bubble(idex_bubble4), .back_en(back_en4), .pc_redirect(pc_redirect4),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = v;   id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd    = rd;  id_regwrite = rw; id_is_load = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; ex_br_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    nop();
    tick(); tick();
    settle();
    check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    check("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
    check("reset_ctrl4", 32'(ctrl4), 32'(C_RESET));
    tick();

    // lw x5 ; add x6,x5,x1
    reset = 1'b0;
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    settle(); check("post_reset_no_stall", 32'(ctrl), 32'(C_RUN)); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    settle(); check("lu_stall", 32'(ctrl), 32'(C_STALL)); tick();
    settle(); check("lu_release", 32'(ctrl), 32'(C_RUN));
    check("lu_stall_cnt", stall_cnt, 32'd1); tick();
    nop();
    settle(); check("lu_fwd_a", 32'(fwd_a), 32'd2); check("lu_fwd_b", 32'(fwd_b), 32'd0); tick();

    // add x5 ; sub x7,x5,x5
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    settle(); check("alu_no_stall", 32'(ctrl), 32'(C_RUN)); tick();
    nop();
    settle(); check("alu_fwd_ab1", 32'({fwd_a, fwd_b}), 32'b0101); tick();

    // add x5 ; nop ; sub x7,x5,x5
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    nop();
    settle(); check("gap_fwd_ab2", 32'({fwd_a, fwd_b}), 32'b1010); tick();

    // add x5 ; add x5 ; add x8,x5,x9 -> newest producer
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0); tick();
    nop();
    settle(); check("newest_fwd_a", 32'(fwd_a), 32'd1); check("newest_fwd_b", 32'(fwd_b), 32'd0); tick();

    // add x0 ; add x10,x0,x0 -> no forwarding from x0
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0); tick();
    nop();
    settle(); check("x0_fwd", 32'({fwd_a, fwd_b}), 32'd0); tick();

    // store-like entry (rd field x5, no regwrite) then reader of x5
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); tick();
    nop();
    settle(); check("no_regwrite_fwd", 32'(fwd_a), 32'd0); tick();

    // taken branch with a load-use in ID
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_br_taken = 1'b1;
    settle(); check("br_over_lu_ctrl", 32'(ctrl), 32'(C_FLUSH)); tick();
    ex_br_taken = 1'b0; nop();
    settle(); check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd1);
    check("br_after_ctrl", 32'(ctrl), 32'(C_RUN)); tick();

    // dmem freeze for 3 cycles with the add->sub forward held
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    nop(); dmem_busy = 1'b1;
    settle(); check("frz1_ctrl", 32'(ctrl), 32'(C_FRZ)); check("frz1_fwd_a", 32'(fwd_a), 32'd1); tick();
    settle(); check("frz2_ctrl", 32'(ctrl), 32'(C_FRZ)); check("frz2_stall_cnt", stall_cnt, 32'd2); tick();
    ex_br_taken = 1'b1;
    settle(); check("frz3_over_br", 32'(ctrl), 32'(C_FRZ)); check("frz3_fwd_a", 32'(fwd_a), 32'd1); tick();
    dmem_busy = 1'b0; ex_br_taken = 1'b0;
    settle(); check("frz_stall_cnt", stall_cnt, 32'd4); check("frz_flush_cnt", flush_cnt, 32'd1);
    check("frz_held_fwd", 32'({fwd_a, fwd_b}), 32'b0101); check("frz_release", 32'(ctrl), 32'(C_RUN)); tick();

    // fetch wait
    imem_busy = 1'b1;
    settle(); check("imem_ctrl", 32'(ctrl), 32'(C_IWAIT)); tick();
    imem_busy = 1'b0;

    // DEPTH=4, LOAD_READY=3 instance
    reset = 1'b1;
    settle(); check("r4_ctrl", 32'(ctrl4), 32'(C_RESET)); tick();
    reset = 1'b0;
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    settle(); check("d4_run", 32'(ctrl4), 32'(C_RUN)); check("d4_cnt0", stall_cnt4, 32'd0);
    check("d3_cnt0_after_reset", stall_cnt, 32'd0); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    settle(); check("d4_stall1", 32'(ctrl4), 32'(C_STALL)); tick();
    settle(); check("d4_stall2", 32'(ctrl4), 32'(C_STALL)); tick();
    settle(); check("d4_release", 32'(ctrl4), 32'(C_RUN)); check("d4_stall_cnt", stall_cnt4, 32'd2); tick();
    nop();
    settle(); check("d4_fwd_a", 32'(fwd_a4), 32'd3); check("d4_fwd_b", 32'(fwd_b4), 32'd0); tick();

    // reset during the 2nd stall cycle discards the hazard
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    settle(); check("d4r_stall1", 32'(ctrl4), 32'(C_STALL)); tick();
    reset = 1'b1;
    settle(); check("d4r_reset_ctrl", 32'(ctrl4), 32'(C_RESET)); check("d4r_reset_fwd", 32'(fwd_a4), 32'd0); tick();
    reset = 1'b0;
    settle(); check("d4r_no_residual", 32'(ctrl4), 32'(C_RUN));
    check("d4r_stall_cnt", stall_cnt4, 32'd0); check("d4r_flush_cnt", flush_cnt4, 32'd0); tick();
    nop();
    settle(); check("d4r_fwd_cleared", 32'(fwd_a4), 32'd0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
